// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, sticky error flag, 1-cycle read latency.
// Optional macro FIFO_ERR_CLR_EN adds an err_clr input that clears fifo_error (a same-cycle error wins).
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef FIFO_ERR_CLR_EN
  input  logic                  err_clr,
`endif
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [4:0]            umbral_alto,
  input  logic [4:0]            umbral_bajo,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic [4:0]            count_ext;
  logic                  wr_ok, rd_ok, err_set;
  state_t                state;

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == DEPTH_CNT);
  assign count_ext    = 5'(count);
  assign almost_full  = (count_ext >= umbral_alto);
  assign almost_empty = (count_ext <= umbral_bajo);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
  assign rd_ok   = pop && !fifo_empty;
  assign wr_ok   = push && (!fifo_full || pop);
  assign err_set = (push && fifo_full && !pop) || (pop && fifo_empty);

  always_comb begin
    count_next = count;
    if (wr_ok && !rd_ok)
      count_next = count + CNT_ONE;
    else if (rd_ok && !wr_ok)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      count     <= count_next;
      valid_out <= rd_ok;
      if (wr_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      fifo_error <= 1'b0;
    else if (err_set)
      fifo_error <= 1'b1;
`ifdef FIFO_ERR_CLR_EN
    else if (err_clr)
      fifo_error <= 1'b0;
`endif
  end

  // Debug-only occupancy state; mirrors the empty/full flags.
  always_ff @(posedge clk) begin
    if (!reset)
      state <= ST_EMPTY;
    else if (wr_ok || rd_ok) begin
      if (count_next == '0)
        state <= ST_EMPTY;
      else if (count_next == DEPTH_CNT)
        state <= ST_FULL;
      else
        state <= ST_PARTIAL;
    end
  end

  state_consistent: assert property (@(posedge clk) disable iff (!reset)
    ((state == ST_EMPTY) == fifo_empty) && ((state == ST_FULL) == fifo_full));

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral: queue-based reference model checked every cycle plus literal spot checks.
module tb_fifo_umbral;
  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [4:0]    umbral_alto = 5'd6;
  logic [4:0]    umbral_bajo = 5'd1;
`ifdef FIFO_ERR_CLR_EN
  logic          err_clr = 1'b0;
`endif
  logic [DW-1:0] data_out;
  logic          valid_out, fifo_empty, fifo_full, almost_full, almost_empty, fifo_error;
  logic [AW:0]   count;

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
`ifdef FIFO_ERR_CLR_EN
    .err_clr(err_clr),
`endif
    .push(push), .pop(pop), .data_in(data_in),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .data_out(data_out), .valid_out(valid_out), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_error(fifo_error), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_q[$];
  logic          m_err = 1'b0;
  logic          m_vld = 1'b0;
  logic [DW-1:0] m_dout = '0;
  logic [DW-1:0] got[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words and the occupancy rules, applied per clock edge.
  task automatic model_update();
    int  sz;
    bit  pop_ok, push_ok, err_now;
    sz = m_q.size();
    if (!reset) begin
      m_q.delete();
      m_err  = 1'b0;
      m_vld  = 1'b0;
      m_dout = '0;
    end else begin
      pop_ok  = pop && (sz != 0);
      push_ok = push && ((sz != DEPTH) || pop);
      err_now = (push && (sz == DEPTH) && !pop) || (pop && (sz == 0));
      m_vld = pop_ok;
      if (pop_ok) m_dout = m_q.pop_front();
      if (push_ok) m_q.push_back(data_in);
      if (err_now) m_err = 1'b1;
`ifdef FIFO_ERR_CLR_EN
      else if (err_clr) m_err = 1'b0;
`endif
    end
  endtask

  task automatic compare();
    int sz;
    sz = m_q.size();
    chk("count",        32'(count),        32'(sz));
    chk("fifo_empty",   32'(fifo_empty),   32'(sz == 0));
    chk("fifo_full",    32'(fifo_full),    32'(sz == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(sz >= int'(umbral_alto)));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= int'(umbral_bajo)));
    chk("fifo_error",   32'(fifo_error),   32'(m_err));
    chk("valid_out",    32'(valid_out),    32'(m_vld));
    chk("data_out",     32'(data_out),     32'(m_dout));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    compare();
    if (valid_out) got.push_back(data_out);
  endtask

  task automatic op(input logic p, input logic q, input logic [DW-1:0] d);
    push = p; pop = q; data_in = d;
    tick();
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic fill_seq();
    for (int i = 1; i <= DEPTH; i++) op(1'b1, 1'b0, DW'(i));
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, '0);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_error", 32'(fifo_error), 32'd0);

    // Fill then drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      op(1'b1, 1'b0, DW'(i));
      if (i == 5) chk("afull_at5", 32'(almost_full), 32'd0);
      if (i == 6) chk("afull_at6", 32'(almost_full), 32'd1);
    end
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(fifo_full), 32'd1);
    got.delete();
    drain();
    chk("drain_n", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++) chk("drain_dat", 32'(got[i]), 32'(i + 1));
    chk("drain_empty", 32'(fifo_empty), 32'd1);

    // Overflow drops the word and sets a sticky error
    fill_seq();
    op(1'b1, 1'b0, 6'h2A);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_err", 32'(fifo_error), 32'd1);
    tick();
    chk("ovf_sticky", 32'(fifo_error), 32'd1);
    got.delete();
    drain();
    chk("ovf_n", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++) chk("ovf_dat", 32'(got[i]), 32'(i + 1));
    chk("ovf_err_end", 32'(fifo_error), 32'd1);

    // Underflow with simultaneous push
    do_reset();
    op(1'b1, 1'b1, 6'h15);
    chk("unf_err", 32'(fifo_error), 32'd1);
    chk("unf_valid", 32'(valid_out), 32'd0);
    chk("unf_count", 32'(count), 32'd1);
    op(1'b0, 1'b1, '0);
    chk("unf_pop_dat", 32'(data_out), 32'h15);
    chk("unf_pop_vld", 32'(valid_out), 32'd1);

    // Push+pop while full, wr_ptr wrap
    do_reset();
    fill_seq();
    op(1'b1, 1'b1, 6'h33);
    chk("pp_count", 32'(count), 32'd8);
    chk("pp_err", 32'(fifo_error), 32'd0);
    chk("pp_dat", 32'(data_out), 32'h01);
    got.delete();
    drain();
    chk("pp_n", 32'(got.size()), 32'd8);
    if (got.size() == 8) begin
      chk("pp_first", 32'(got[0]), 32'h02);
      chk("pp_last", 32'(got[7]), 32'h33);
    end

    // Threshold extremes and same-cycle threshold response
    do_reset();
    umbral_alto = 5'd0;
    tick();
    chk("ua0_afull", 32'(almost_full), 32'd1);
    umbral_alto = 5'd9;
    fill_seq();
    chk("ua9_afull", 32'(almost_full), 32'd0);
    umbral_bajo = 5'd7;
    #1;
    chk("ub7_aempty", 32'(almost_empty), 32'd0);
    umbral_bajo = 5'd8;
    #1;
    chk("ub8_aempty", 32'(almost_empty), 32'd1);
    tick();

    // Reset mid-operation discards contents
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
    umbral_alto = 5'd5;
    umbral_bajo = 5'd2;

    // Mixed traffic against the model
    for (int i = 0; i < 300; i++)
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));

`ifdef FIFO_ERR_CLR_EN
    do_reset();
    fill_seq();
    op(1'b1, 1'b0, 6'h2A);
    chk("clr_pre", 32'(fifo_error), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_done", 32'(fifo_error), 32'd0);
    err_clr = 1'b1;
    op(1'b1, 1'b0, 6'h2B);
    err_clr = 1'b0;
    chk("clr_set_wins", 32'(fifo_error), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
